// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: comma-aligned 1:8 deserializer; `define LOSS_OF_LOCK_EN adds gap-based loss of lock.
module serial_to_parallel_rx #(
  parameter logic [7:0] COMMA = 8'hBC,
  parameter int LOCK_COUNT = 4,
  parameter int LOL_GAP = 64
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);
  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;
  state_t state, state_n;
  logic [6:0] sr;
  logic [7:0] nb, data_n;
  logic [2:0] bit_cnt, bit_n;
  logic [3:0] bc_cnt, bc_n;
  logic valid_n, strobe_n, active_n, is_comma, bnd, lol;
  if (LOCK_COUNT < 1 || LOCK_COUNT > 15 || LOL_GAP < 1 || LOL_GAP > 255) begin : g_bad_param
    $error("serial_to_parallel_rx: LOCK_COUNT or LOL_GAP out of range");
  end
  assign nb = {sr, data_in};
  assign is_comma = nb == COMMA;
  assign bnd = state != HUNT && bit_cnt == 3'd7;
`ifdef LOSS_OF_LOCK_EN
  logic [7:0] gap, gap_n;
  // gap counts consecutive non-comma bytes seen while locked
  assign gap_n = (state != LOCKED || (bnd && is_comma)) ? 8'd0 : bnd ? gap + 8'd1 : gap;
  assign lol = state == LOCKED && bnd && !is_comma && gap + 8'd1 == LOL_GAP[7:0];
  always_ff @(posedge clk_32f) gap <= reset ? 8'd0 : gap_n;
`else
  assign lol = 1'b0;
`endif
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state <= HUNT;
      sr <= '0;
      bit_cnt <= '0;
      bc_cnt <= '0;
      data_out <= '0;
      valid_out <= 1'b0;
      byte_strobe <= 1'b0;
      active <= 1'b0;
    end else begin
      state <= state_n;
      sr <= nb[6:0];
      bit_cnt <= bit_n;
      bc_cnt <= bc_n;
      data_out <= data_n;
      valid_out <= valid_n;
      byte_strobe <= strobe_n;
      active <= active_n;
    end
  end
  always_comb begin
    state_n = state == HUNT   ? (is_comma ? (LOCK_COUNT == 1 ? LOCKED : ALIGN) : HUNT)
            : state == ALIGN  ? (!bnd ? ALIGN : !is_comma ? HUNT
                                 : (bc_cnt + 4'd1 == LOCK_COUNT[3:0]) ? LOCKED : ALIGN)
            : state == LOCKED ? (lol ? HUNT : LOCKED)
            : HUNT;
    bit_n = state == HUNT ? 3'd0 : bit_cnt + 3'd1;
    bc_n = state == HUNT ? (is_comma ? 4'd1 : 4'd0)
         : (state == ALIGN && bnd) ? (is_comma ? bc_cnt + 4'd1 : 4'd0)
         : bc_cnt;
  end
  always_comb begin
    strobe_n = state == LOCKED && bnd && !lol;
    active_n = state_n == LOCKED;
    valid_n = lol ? 1'b0 : strobe_n ? !is_comma : valid_out;
    data_n = lol ? 8'h00 : strobe_n ? (is_comma ? 8'h00 : nb) : data_out;
  end
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: random/directed bit streams vs. a byte-level reference model with a strobe scoreboard.
module tb_serial_to_parallel_rx;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam int LC = 4;
`ifdef LOSS_OF_LOCK_EN
  localparam int LG = 4;
  localparam bit LOL = 1'b1;
`else
  localparam int LG = 64;
  localparam bit LOL = 1'b0;
`endif
  localparam int MAXC = 8192;
  typedef struct {int cyc; logic [7:0] data; logic valid;} ev_t;
  logic clk_32f = 1'b0, reset = 1'b1, data_in = 1'b0;
  logic [7:0] data_out;
  logic valid_out, byte_strobe, active;
  int total = 0, bad = 0, n = 0, cyc = 0;
  ev_t q[$];
  logic [7:0] exp_dat [MAXC];
  logic exp_val [MAXC];
  logic exp_act [MAXC];
  bit hist[$];
  bit m_lock = 0, m_align = 0, m_valid = 0;
  logic [7:0] m_data = 0;
  int anchor = 0, ncom = 0, gap = 0;

  serial_to_parallel_rx #(.COMMA(COMMA), .LOCK_COUNT(LC), .LOL_GAP(LG)) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .data_out(data_out),
    .valid_out(valid_out), .byte_strobe(byte_strobe), .active(active));

  initial forever #5 clk_32f = ~clk_32f;
  always @(posedge clk_32f) cyc <= cyc + 1;

  function automatic logic [7:0] window();
    logic [7:0] w = 8'h00;
    for (int k = 0; k < 8; k++) begin
      int idx = hist.size() - 8 + k;
      w = {w[6:0], idx >= 0 ? logic'(hist[idx]) : 1'b0};
    end
    return w;
  endfunction

  // Reference: last 8 bits since reset form the candidate byte; after the first
  // comma, bytes are taken every 8th bit counted from that comma's last bit.
  task automatic model(input bit r, input bit b);
    logic [7:0] w;
    if (r) begin
      hist.delete();
      m_lock = 0; m_align = 0; m_valid = 0; m_data = 0; gap = 0;
    end else begin
      hist.push_back(b);
      w = window();
      if (!m_lock && !m_align) begin
        if (w == COMMA) begin
          anchor = n; ncom = 1;
          if (LC == 1) begin m_lock = 1; gap = 0; end else m_align = 1;
        end
      end else if ((n - anchor) % 8 == 0) begin
        if (m_align) begin
          if (w == COMMA) begin
            ncom++;
            if (ncom == LC) begin m_align = 0; m_lock = 1; gap = 0; end
          end else m_align = 0;
        end else begin
          gap = (w == COMMA) ? 0 : gap + 1;
          if (LOL && gap == LG) begin
            m_lock = 0; m_valid = 0; m_data = 0;
          end else begin
            m_valid = w != COMMA;
            m_data = m_valid ? w : 8'h00;
            q.push_back('{n, m_data, m_valid});
          end
        end
      end
    end
    exp_act[n] = m_lock; exp_val[n] = m_valid; exp_dat[n] = m_data;
  endtask

  task automatic send_bit(input bit r, input bit b);
    model(r, b);
    reset = r; data_in = b;
    @(posedge clk_32f); #1;
    n++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) send_bit(0, v[k]);
  endtask

  task automatic commas(input int c);
    repeat (c) send_byte(COMMA);
  endtask

  always @(negedge clk_32f) begin
    int e;
    ev_t ev;
    e = cyc - 1;
    if (e >= 0 && e < n) begin
      total++;
      if (active !== exp_act[e] || valid_out !== exp_val[e] || data_out !== exp_dat[e]) begin
        bad++;
        $display("FAIL outputs cycle=%0d got act=%b val=%b dat=%h want act=%b val=%b dat=%h",
                 e, active, valid_out, data_out, exp_act[e], exp_val[e], exp_dat[e]);
      end
      if (byte_strobe === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL strobe cycle=%0d got unexpected strobe want none", e);
        end else begin
          ev = q.pop_front();
          if (ev.cyc != e || ev.data !== data_out || ev.valid !== valid_out) begin
            bad++;
            $display("FAIL strobe cycle=%0d got dat=%h val=%b want cycle=%0d dat=%h val=%b",
                     e, data_out, valid_out, ev.cyc, ev.data, ev.valid);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= e) begin
        total++; bad++;
        $display("FAIL strobe cycle=%0d got strobe=%b want strobe at cycle=%0d", e, byte_strobe, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    send_bit(1, 1); send_bit(1, 0);
    repeat (7) send_bit(0, 1'($urandom));
    commas(4); send_byte(8'h12); send_byte(8'h34); send_byte(COMMA); send_byte(8'h56);
    send_bit(1, 0);
    commas(3); send_byte(8'h55); commas(4); send_byte(8'h9E);
    send_bit(1, 0);
    send_bit(0, 1); send_bit(0, 0); send_bit(0, 1);
    commas(4); send_byte(8'hA7); send_byte(COMMA);
    send_bit(0, 1); send_bit(0, 1); send_bit(0, 0);
    send_bit(1, 0);
    repeat (5) send_bit(0, 1'($urandom));
    send_byte(8'h11); commas(4);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    commas(4); send_byte(8'h66);
    repeat (25) begin
      if ($urandom_range(0, 5) == 0) send_bit(1, 1'($urandom));
      repeat ($urandom_range(0, 7)) send_bit(0, 1'($urandom));
      commas($urandom_range(2, 5));
      repeat ($urandom_range(1, 6)) send_byte($urandom_range(0, 3) == 0 ? COMMA : 8'($urandom));
    end
    @(negedge clk_32f); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending got %0d unserved strobes want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
